// File: rtl/sd_dac_tx_pkg.sv
// Shared definitions for the sigma-delta DAC transmit path.
// SD_SAMPLE_W is the sample width also used by the SAR ADC path.
package sd_dac_tx_pkg;

    localparam int SD_SAMPLE_W    = 8;
    localparam int SD_PERIOD_LOG2 = 8;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    typedef struct packed {
        logic tick;
        logic underrun;
    } sd_strobe_t;

    // A period boundary is the last count before the counter wraps.
    function automatic logic is_boundary(input logic [31:0] cnt, input int log2);
        logic [31:0] mask;
        mask = (32'd1 << log2) - 32'd1;
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/sd_dac_tx_modulator.sv
// First-order sigma-delta modulator: the accumulator carry-out is the
// 1-bit output, so the pulse density of DACout equals Current / 2^WIDTH.
module sd_modulator
    import sd_dac_tx_pkg::*;
#(
    parameter int WIDTH = SD_SAMPLE_W
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Current,
    output logic             DACout
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             dac_q, dac_d;

    always_comb begin
        {dac_d, acc_d} = {1'b0, acc_q} + {1'b0, Current};
    end

    // The residue is kept across sample changes so no density error is lost.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

    assign DACout = dac_q;

endmodule

// File: rtl/sd_dac_tx.sv
// Sigma-delta DAC transmitter: one-entry sample buffer with ready/valid input,
// free-running sample-period pacing, underrun and sample-rate strobes.
module sd_dac_tx
    import sd_dac_tx_pkg::*;
#(
    parameter int WIDTH       = SD_SAMPLE_W,
    parameter int PERIOD_LOG2 = SD_PERIOD_LOG2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    output logic             DACout,
    output logic             SampleTick,
    output logic             Underrun
);

    logic [PERIOD_LOG2-1:0] period_q, period_d;
    buf_state_t             full_q, full_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic [WIDTH-1:0]       cur_q, cur_d;
    sd_strobe_t             strobe_q, strobe_d;
    logic                   boundary;
    logic                   accept;

    assign boundary = is_boundary(32'(period_q), PERIOD_LOG2);
    assign accept   = DataValid && (full_q == BUF_EMPTY);

    // A consuming boundary and an accept are mutually exclusive because the
    // buffer is only ready while empty.
    always_comb begin
        period_d          = period_q + PERIOD_LOG2'(1);
        full_d            = full_q;
        hold_d            = hold_q;
        cur_d             = cur_q;
        strobe_d.tick     = boundary;
        strobe_d.underrun = boundary && (full_q == BUF_EMPTY);
        if (boundary && (full_q == BUF_FULL)) begin
            cur_d  = hold_q;
            full_d = BUF_EMPTY;
        end else if (accept) begin
            hold_d = DataIn;
            full_d = BUF_FULL;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            period_q <= '0;
            full_q   <= BUF_EMPTY;
            hold_q   <= '0;
            cur_q    <= '0;
            strobe_q <= '0;
        end else begin
            period_q <= period_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            cur_q    <= cur_d;
            strobe_q <= strobe_d;
        end
    end

    assign DataReady  = (full_q == BUF_EMPTY);
    assign SampleTick = strobe_q.tick;
    assign Underrun   = strobe_q.underrun;

    sd_modulator #(
        .WIDTH(WIDTH)
    ) u_mod (
        .CLK    (CLK),
        .Reset  (Reset),
        .Current(cur_q),
        .DACout (DACout)
    );

endmodule

// File: tb/tb_sd_dac_tx.sv
// Scoreboard bench for sd_dac_tx: a cumulative-sum reference model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_sd_dac_tx;

    localparam int W   = 8;
    localparam int PL  = 8;
    localparam int PER = 1 << PL;

    localparam int M_IDLE  = 0;
    localparam int M_PROD  = 1;
    localparam int M_HOLDV = 2;
    localparam int M_RAND  = 3;

    logic         CLK = 1'b0;
    logic         Reset = 1'b0;
    logic [W-1:0] DataIn = '0;
    logic         DataValid = 1'b0;
    logic         DataReady, DACout, SampleTick, Underrun;

    sd_dac_tx #(.WIDTH(W), .PERIOD_LOG2(PL)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .DataIn    (DataIn),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .DACout    (DACout),
        .SampleTick(SampleTick),
        .Underrun  (Underrun)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic dac;
        logic tick;
        logic under;
        logic ready;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;

    // Reference model state: sample buffer as plain variables, modulator as
    // the running sum of all applied samples (a one is emitted each time the
    // sum crosses a multiple of 2^W).
    int              cyc;
    bit              m_full;
    int              m_hold, m_cur;
    longint unsigned m_sum;

    int mode, inj_cyc, inj_dat, idx;
    int words[2] = '{8'hFF, 8'h80};
    int win_lo, win_hi, win_ones;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (time %0t, cycle %0d)", name, act, expv, $time, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!Reset && sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("DACout",     longint'(DACout),     longint'(mon_e.dac));
            chk("SampleTick", longint'(SampleTick), longint'(mon_e.tick));
            chk("Underrun",   longint'(Underrun),   longint'(mon_e.under));
            chk("DataReady",  longint'(DataReady),  longint'(mon_e.ready));
        end
    end

    task automatic do_reset();
        exp_t e;
        Reset = 1'b1;
        DataValid = 1'b0;
        DataIn = '0;
        #1;
        chk("rst_DACout",     longint'(DACout),     0);
        chk("rst_SampleTick", longint'(SampleTick), 0);
        chk("rst_Underrun",   longint'(Underrun),   0);
        chk("rst_DataReady",  longint'(DataReady),  1);
        sb.delete();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        cyc = 0; m_full = 0; m_hold = 0; m_cur = 0; m_sum = 0;
        inj_cyc = -1; inj_dat = 0; idx = 0; mode = M_IDLE;
        win_lo = -1; win_hi = -2; win_ones = 0;
        e = '{dac: 1'b0, tick: 1'b0, under: 1'b0, ready: 1'b1};
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        exp_t e;
        bit   bnd;
        if (cyc >= win_lo && cyc <= win_hi) win_ones += int'(DACout);
        DataValid = v;
        DataIn = d;
        @(posedge CLK);
        bnd = (cyc % PER) == PER - 1;
        e.tick  = bnd;
        e.under = bnd && !m_full;
        e.dac   = ((m_sum + longint'(m_cur)) >> W) != (m_sum >> W);
        m_sum  += longint'(m_cur);
        if (bnd && m_full) begin
            m_cur  = m_hold;
            m_full = 0;
        end else if (v && !m_full) begin
            m_hold = int'(d);
            m_full = 1;
        end
        e.ready = !m_full;
        sb.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic run_until(input int end_c);
        logic         v;
        logic [W-1:0] d;
        while (cyc < end_c) begin
            v = 1'b0;
            d = '0;
            case (mode)
                M_PROD: if (SampleTick && idx < 2) begin
                    v = 1'b1; d = W'(words[idx]); idx++;
                end
                M_HOLDV: begin v = 1'b1; d = W'($urandom); end
                M_RAND:  begin v = ($urandom_range(0, 3) == 0); d = W'($urandom); end
                default: ;
            endcase
            if (cyc == inj_cyc) begin v = 1'b1; d = W'(inj_dat); end
            step(v, d);
        end
    endtask

    task automatic win(input int lo, input int hi, input int expv, input string name);
        win_lo = lo; win_hi = hi; win_ones = 0;
        run_until(hi + 1);
        chk(name, win_ones, expv);
    endtask

    initial begin
        #2;
        // Idle after reset: silent output, single underrun at cycle 256.
        do_reset();
        win(0, 259, 0, "idle_ones");

        // Single 0x40 accepted in cycle 3: 64 ones per full window.
        do_reset();
        inj_cyc = 3; inj_dat = 8'h40;
        win(257, 512, 64, "x40_win1");
        win(513, 768, 64, "x40_win2");

        // Producer paced by SampleTick: 0x00, 0xFF, 0x80 with no underrun.
        do_reset();
        mode = M_PROD; inj_cyc = 0; inj_dat = 8'h00;
        win(257, 512, 0,   "prod_x00");
        win(513, 768, 255, "prod_xFF");
        win(769, 1024, 128, "prod_x80");

        // Valid exactly on an empty boundary: underrun, takes effect one period later.
        do_reset();
        inj_cyc = PER - 1; inj_dat = 8'h10;
        win(257, 512, 0,  "bnd_accept_unchanged");
        win(513, 768, 16, "bnd_accept_applied");

        // Valid held high while full: later DataIn values are ignored.
        do_reset();
        mode = M_HOLDV; inj_cyc = 0; inj_dat = 8'h33;
        win(257, 512, 51, "hold_ignored");

        // Random producer traffic.
        do_reset();
        mode = M_RAND;
        run_until(3000);

        // Asynchronous reset mid-period with Full=1 and Current=0xAA.
        do_reset();
        inj_cyc = 0; inj_dat = 8'hAA;
        run_until(PER);
        inj_cyc = PER; inj_dat = 8'h55;
        run_until(300);
        do_reset();
        win(0, 259, 0, "post_reset_idle");

        #6;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_dac_tx.md
# sd_dac_tx

First-order sigma-delta DAC transmitter with a one-entry sample buffer and a ready/valid input handshake. It accepts parallel samples from the game logic, for example paddle-position echoes or audio levels, and converts each one to a 1-bit pulse-density stream on `DACout` for an external RC filter. It is the output-direction counterpart of the successive-approximation ADC path. A free-running sample-period counter paces sample consumption, flags underruns, and gives the producer a sample-rate strobe.

## Interface
- `WIDTH`, default 8: sample width in bits; sets modulator resolution.
- `PERIOD_LOG2`, default 8: log2 of clock cycles per sample period; must be ≥ 1.

- `CLK`  in  1: clock, all logic on rising edge.
- `Reset`  in  1: reset, asynchronous, active-high.
- `DataIn`  in  `WIDTH`: sample to convert, unsigned; 0 gives all-zero output.
- `DataValid`  in  1: producer offers `DataIn` this cycle.
- `DataReady`  out  1: buffer can accept; transfer occurs when `DataValid & DataReady` at a rising edge.
- `DACout`  out  1: pulse-density output, registered.
- `SampleTick`  out  1: one-cycle pulse after each sample-period boundary.
- `Underrun`  out  1: one-cycle pulse when a boundary found the buffer empty.

## Operation
- State:
  - `PeriodCnt[PERIOD_LOG2-1:0]`
  - `Hold[WIDTH-1:0]` with `Full` flag
  - `Current[WIDTH-1:0]`, the active sample
  - `Acc[WIDTH-1:0]`, the modulator residue
- `PeriodCnt` increments every cycle and wraps naturally. A boundary is `PeriodCnt == all ones`.
- `DataReady = ~Full`, combinational from the flag only. It does not depend on `DataValid` or the boundary.
- Accept: on a handshake edge, `Hold <= DataIn`, `Full <= 1`.
- Boundary with `Full = 1`: `Current <= Hold`, `Full <= 0`.
- Boundary with `Full = 0`: `Current` keeps its value and `Underrun` pulses.
- Boundary coincides with an accept while `Full = 0`:
  - An underrun is reported and `Current` is unchanged.
  - The accepted word lands in `Hold`, `Full <= 1`, and is consumed at the next boundary.
- A boundary with `Full = 1` cannot coincide with an accept, because `DataReady = 0`.
- Modulator, every cycle: `{carry, Acc} <= Acc + Current` at `WIDTH+1` bits, and `DACout <= carry`.
  - `Acc` is never cleared except by `Reset`; the residue carries across sample changes.
- Density rule: for constant `Current = x`, any `2^WIDTH` consecutive `DACout` cycles contain exactly `x` ones.
  - `x = 0` gives a constant 0.
  - Full scale (`2^WIDTH - 1`) gives one 0 per `2^WIDTH` cycles.
- Reset mid-operation clears all state immediately, discarding the buffered sample and the residue.

## Timing
- Reset values: `DACout = 0`, `SampleTick = 0`, `Underrun = 0`, `DataReady = 1`. Internal `PeriodCnt`, `Acc`, `Current`, `Hold` and `Full` are all 0.
- First boundary after reset is at cycle `2^PERIOD_LOG2 - 1`. That boundary underruns unless a word was accepted earlier.
- `SampleTick` and `Underrun` are registered: high for the one cycle after the boundary edge.
- Latency:
  - Accept edge to `Hold` valid: 1 edge.
  - Boundary edge to `Current` updated: 1 edge.
  - First `Acc` update using the new `Current`: the next edge.
  - `DACout` reflects the new sample from the second edge after the boundary.
- `DataReady` rises in the cycle after a consuming boundary. The producer reacting to `SampleTick` can therefore hand over exactly one word per period with no underrun.

## Structure
- `WIDTH` default comes from the shared sample-width define already used by the ADC path, so both directions agree on resolution.
- `PERIOD_LOG2` stays a local parameter.
- One sub-module, `sd_modulator`: inputs `CLK`, `Reset`, `Current`; holds `Acc` and registers `DACout`.
- The buffer, period counter and strobes live in `sd_dac_tx`.

## Test plan
- Reset, then no input for 256 cycles (defaults) → `DACout` stays 0; `Underrun` pulses once at cycle 256; `DataReady` held 1.
- Accept `0x40` in cycle 3 → `DataReady` low from cycle 4 until the boundary; `SampleTick` at cycle 256. In each subsequent 256-cycle window, `DACout` has exactly 64 ones and periodicity 4.
- Producer feeds `0x00`, `0xFF`, `0x80` on successive `SampleTick`s → no `Underrun`. Per-period ones counts are 0, 255, 128, measured from 2 cycles after each boundary.
- `DataValid` asserted exactly on the boundary cycle with `Full = 0` and `DataIn = 0x10` → `Underrun` pulses; `Current` unchanged this period; `0x10` takes effect at the following boundary.
- Hold `DataValid` high with `Full = 1` → no transfer; `Hold` unchanged; `DataIn` changes are ignored until `DataReady` returns.
- Assert `Reset` mid-period with `Full = 1` and `Current = 0xAA` → all outputs return to their reset values asynchronously. After release, the behaviour matches a fresh reset.
